// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit 2-of-3 majority voting,
// single-cycle done / frame-error pulses and a held data register.
module uart_rx_oversample #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       iclk,
    input  logic       s_rst_n,
    input  logic       uart_rx_i,
    output logic [7:0] uart_rx_data_o,
    output logic       uart_rx_done,
    output logic       uart_frame_err,
    output logic       rx_busy
);

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int HALF   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(HALF + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t state, state_next;

    logic              rx_meta;
    logic              rx_s;
    logic              rx_s_d;
    logic [1:0]        warm;
    logic              fall;

    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [2:0]        bit_idx;
    logic              smp_a, smp_b;
    logic              maj;
    logic              wrap, decide;
    logic [DATA_W-1:0] shreg;

    logic              done_next, err_next, load, shift;

    // Synchronizer stage; warm masks the reset-forced highs so a line that is
    // already low when reset releases is not mistaken for a start edge.
    always_ff @(posedge iclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
            warm    <= 2'd0;
        end else begin
            rx_meta <= uart_rx_i;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
            if (warm != 2'd3) warm <= warm + 2'd1;
        end
    end

    assign fall   = (warm == 2'd3) && !rx_s && rx_s_d;
    assign wrap   = (cnt == CNT_LAST);
    assign decide = (cnt == SMP_C);
    assign maj    = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

    // Mid-bit samples; the third vote is the live rx_s at the decision cycle.
    always_ff @(posedge iclk) begin
        if (cnt == SMP_A) smp_a <= rx_s;
        if (cnt == SMP_B) smp_b <= rx_s;
    end

    always_comb begin
        state_next = state;
        cnt_next   = wrap ? '0 : cnt + CNT_W'(1);
        done_next  = 1'b0;
        err_next   = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (fall) state_next = START;
            end
            START: begin
                if (decide && maj) state_next = IDLE;
                else if (wrap)     state_next = DATA;
            end
            DATA: begin
                if (decide) shift = 1'b1;
                if (wrap && bit_idx == 3'd7) state_next = STOP;
            end
            STOP: begin
                if (decide) begin
                    if (maj) begin
                        load       = 1'b1;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state) cnt_next = '0;
    end

    always_ff @(posedge iclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            uart_rx_done   <= 1'b0;
            uart_frame_err <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            uart_rx_done   <= done_next;
            uart_frame_err <= err_next;
        end
    end

    // Assembly stage: LSB-first shift, then a single load into the output.
    always_ff @(posedge iclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            bit_idx        <= 3'd0;
            shreg          <= '0;
            uart_rx_data_o <= '0;
        end else begin
            if (state != DATA)  bit_idx <= 3'd0;
            else if (wrap)      bit_idx <= bit_idx + 3'd1;
            if (shift)          shreg <= {maj, shreg[DATA_W-1:1]};
            if (load)           uart_rx_data_o <= shreg;
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Randomized bench for uart_rx_oversample with a frame-level reference model
// that decodes the synchronized line from sample offsets relative to the start edge.
module tb_uart_rx_oversample;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       s_rst_n;
    logic       uart_rx_i;
    logic [7:0] uart_rx_data_o;
    logic       uart_rx_done;
    logic       uart_frame_err;
    logic       rx_busy;

    uart_rx_oversample #(.CLKS_PER_BIT(CPB)) dut (
        .iclk           (clk),
        .s_rst_n        (s_rst_n),
        .uart_rx_i      (uart_rx_i),
        .uart_rx_data_o (uart_rx_data_o),
        .uart_rx_done   (uart_rx_done),
        .uart_frame_err (uart_frame_err),
        .rx_busy        (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    longint     edge_cnt = 0;
    bit         hist [0:1023];
    bit         s1 = 1'b1;
    int         since = 0;
    int         mode = 0;            // 0 idle, 1 in frame, 2 waiting for line high
    longint     t0 = 0;
    logic [7:0] mbits = 8'h00;
    logic [7:0] exp_data = 8'h00;
    bit         exp_done = 1'b0;
    bit         exp_err = 1'b0;

    // Observation log
    logic [7:0] got_q [$];
    int         n_done = 0;
    int         n_err = 0;
    longint     done_edge = 0;
    bit         busy_seen = 1'b0;
    longint     fall_edge = 0;

    function automatic int h(input longint i);
        return int'(hist[int'(i % 1024)]);
    endfunction

    always @(posedge clk) begin
        #1;
        edge_cnt++;
        if (!s_rst_n) begin
            s1 = 1'b1;
            hist[int'(edge_cnt % 1024)] = 1'b1;
            mode = 0;
            since = 0;
            exp_data = 8'h00;
            exp_done = 1'b0;
            exp_err = 1'b0;
        end else begin
            longint off;
            int     k, votes;
            since++;
            exp_done = 1'b0;
            exp_err = 1'b0;
            case (mode)
                0: if (since >= 4 && h(edge_cnt-1) == 0 && h(edge_cnt-2) == 1) begin
                       mode = 1;
                       t0 = edge_cnt;
                   end
                1: begin
                    off = edge_cnt - t0;
                    if (off >= HALF + 2 && (off - (HALF + 2)) % CPB == 0) begin
                        k = int'((off - (HALF + 2)) / CPB);
                        votes = h(t0 + k*CPB + HALF - 1) + h(t0 + k*CPB + HALF) + h(t0 + k*CPB + HALF + 1);
                        if (k == 0) begin
                            if (votes >= 2) mode = 0;
                        end else if (k <= 8) begin
                            mbits[k-1] = (votes >= 2);
                        end else if (votes >= 2) begin
                            exp_data = mbits;
                            exp_done = 1'b1;
                            mode = 0;
                        end else begin
                            exp_err = 1'b1;
                            mode = 2;
                        end
                    end
                end
                default: if (h(edge_cnt-1) == 1) mode = 0;
            endcase
            hist[int'(edge_cnt % 1024)] = s1;
            s1 = uart_rx_i;
        end
        check("done", uart_rx_done, exp_done);
        check("frame_err", uart_frame_err, exp_err);
        check("data", uart_rx_data_o, exp_data);
        check("busy", rx_busy, (s_rst_n && mode != 0));
        if (uart_rx_done) begin
            got_q.push_back(uart_rx_data_o);
            n_done++;
            done_edge = edge_cnt;
        end
        if (uart_frame_err) n_err++;
        if (rx_busy) busy_seen = 1'b1;
    end

    task automatic idle(input int n);
        uart_rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // gk: frame bit index (0 start, 1..8 data, 9 stop) to invert for one cycle at offset go
    task automatic send_frame(input logic [7:0] b, input bit stop, input int gk, input int go);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < CPB; c++) begin
                uart_rx_i = fr[k] ^ (k == gk && c == go);
                if (k == 0 && c == 0) fall_edge = edge_cnt + 1;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n0, e0, q0;
        logic [7:0] exp_q [$];
        logic [9:0] fr;
        logic [7:0] b;
        bit         stop;
        int         gk;

        uart_rx_i = 1'b1;
        s_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", uart_rx_data_o, 8'h00);
        check("rst_done", uart_rx_done, 1'b0);
        check("rst_err", uart_frame_err, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        s_rst_n = 1'b1;
        idle(CPB);

        // 0xA5: done 156 edges after the line falls (2 sync + 9*16+8+2)
        n0 = n_done; e0 = n_err;
        send_frame(8'hA5, 1'b1, -1, 0);
        idle(2*CPB);
        check("a5_count", n_done - n0, 1);
        check("a5_latency", done_edge - fall_edge, 156);
        check("a5_data", uart_rx_data_o, 8'hA5);
        check("a5_err", n_err - e0, 0);

        // 4-cycle low glitch on idle line
        n0 = n_done; e0 = n_err; busy_seen = 1'b0;
        uart_rx_i = 1'b0;
        repeat (4) @(negedge clk);
        idle(2*CPB);
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_busy_end", rx_busy, 1'b0);
        check("glitch_done", n_done - n0, 0);
        check("glitch_err", n_err - e0, 0);

        // 0x3C with a low stop bit
        n0 = n_done; e0 = n_err;
        send_frame(8'h3C, 1'b0, -1, 0);
        idle(2*CPB);
        check("ferr_count", n_err - e0, 1);
        check("ferr_done", n_done - n0, 0);
        check("ferr_data_kept", uart_rx_data_o, 8'hA5);
        check("ferr_busy_end", rx_busy, 1'b0);

        // Back-to-back 0x00 then 0xFF
        n0 = n_done; q0 = got_q.size();
        send_frame(8'h00, 1'b1, -1, 0);
        send_frame(8'hFF, 1'b1, -1, 0);
        idle(2*CPB);
        check("b2b_count", n_done - n0, 2);
        if (got_q.size() >= q0 + 2) begin
            check("b2b_first", got_q[q0], 8'h00);
            check("b2b_second", got_q[q0+1], 8'hFF);
        end

        // 0x55 with a 1-cycle inversion mid bit 3
        send_frame(8'h55, 1'b1, 4, HALF);
        idle(2*CPB);
        check("glitch55_data", uart_rx_data_o, 8'h55);

        // Reset asserted during bit 4
        n0 = n_done; e0 = n_err;
        fr = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5*CPB + HALF; i++) begin
            uart_rx_i = fr[i / CPB];
            @(negedge clk);
        end
        s_rst_n = 1'b0;
        #1;
        check("midrst_data", uart_rx_data_o, 8'h00);
        check("midrst_busy", rx_busy, 1'b0);
        check("midrst_done", uart_rx_done, 1'b0);
        uart_rx_i = 1'b1;
        repeat (4) @(negedge clk);
        s_rst_n = 1'b1;
        idle(2*CPB);
        check("midrst_no_pulse", (n_done - n0) + (n_err - e0), 0);
        send_frame(8'h81, 1'b1, -1, 0);
        idle(2*CPB);
        check("post_rst_data", uart_rx_data_o, 8'h81);
        check("post_rst_count", n_done - n0, 1);

        // Line already low at reset release must not start a frame
        uart_rx_i = 1'b0;
        s_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        busy_seen = 1'b0;
        s_rst_n = 1'b1;
        repeat (3*CPB) @(negedge clk);
        check("low_release_busy", busy_seen, 1'b0);
        idle(2*CPB);

        // Randomized frames
        q0 = got_q.size();
        for (int f = 0; f < 40; f++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 9) != 0);
            gk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
            send_frame(b, stop, gk, int'($urandom_range(0, CPB-1)));
            if (stop) begin
                exp_q.push_back(b);
                idle(int'($urandom_range(0, 3*CPB)));
            end else begin
                idle(int'($urandom_range(CPB, 3*CPB)));
            end
        end
        idle(2*CPB);
        check("rand_count", got_q.size() - q0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (q0 + i < got_q.size()) check("rand_byte", got_q[q0+i], exp_q[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
